// File: rtl/ecpri_resp_sched_if.sv
// Tx byte stream and buffer-RAM read port between the eCPRI response scheduler
// and its neighbours (switch on the stream side, shared rx/tx buffer on the RAM side).
interface ecpri_resp_sched_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        to_switch;
   logic              tx_valid;
   logic              tx_last;
   logic              tx_ready;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_data;

   modport master (
      output to_switch, tx_valid, tx_last, mem_rd_en, mem_addr,
      input  tx_ready, mem_data
   );

   modport slave (
      input  to_switch, tx_valid, tx_last, mem_rd_en, mem_addr,
      output tx_ready, mem_data
   );
endinterface

// File: rtl/ecpri_resp_sched.sv
// eCPRI remote-memory-access response scheduler: round-robin write/read response
// grant, 4-byte common header, then read payload fetched byte-by-byte from buffer RAM.
module ecpri_resp_sched #(
   parameter int          ADDR_W = 8,
   parameter logic [7:0]  HDR_B0 = 8'h10,
   parameter logic [7:0]  HDR_B1 = 8'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send_write_resp,
   input  logic       send_read_resp,
   input  logic [7:0] tx_payload_len,
   output logic       wr_ack,
   output logic       rd_ack,
   output logic       busy,
   ecpri_resp_sched_if.master bus
);

   typedef enum logic [2:0] {IDLE, HDR, FETCH, LOAD, SEND} state_t;

   state_t            state_q, state_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        len_q, len_d;
   logic [7:0]        byte_q, byte_d;
   logic              vld_q, vld_d;
   logic              last_q, last_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_ack_q, rd_ack_d;
   logic              lg_rd_q, lg_rd_d;   // last grant was a read response
   logic              accept;
   logic              grant_wr;

   function automatic logic [7:0] hdr_byte(input logic [1:0] i, input logic [7:0] len);
      case (i)
         2'd0:    hdr_byte = HDR_B0;
         2'd1:    hdr_byte = HDR_B1;
         2'd2:    hdr_byte = 8'h00;
         default: hdr_byte = len;
      endcase
   endfunction

   assign accept   = vld_q & bus.tx_ready;
   assign grant_wr = send_write_resp & (~send_read_resp | lg_rd_q);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      byte_d   = byte_q;
      vld_d    = vld_q;
      last_d   = last_q;
      rd_en_d  = 1'b0;
      addr_d   = addr_q;
      wr_ack_d = 1'b0;
      rd_ack_d = 1'b0;
      lg_rd_d  = lg_rd_q;
      case (state_q)
         IDLE: begin
            if (send_write_resp | send_read_resp) begin
               state_d  = HDR;
               wr_ack_d = grant_wr;
               rd_ack_d = ~grant_wr;
               lg_rd_d  = ~grant_wr;
               len_d    = grant_wr ? 8'd0 : tx_payload_len;
               idx_d    = 8'd0;
               byte_d   = HDR_B0;
               vld_d    = 1'b1;
               last_d   = 1'b0;
            end
         end
         HDR: begin
            if (accept) begin
               if (idx_q[1:0] == 2'd3) begin
                  vld_d  = 1'b0;
                  last_d = 1'b0;
                  idx_d  = 8'd0;
                  if (len_q == 8'd0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = FETCH;
                     rd_en_d = 1'b1;
                     addr_d  = '0;
                  end
               end else begin
                  idx_d  = idx_q + 8'd1;
                  byte_d = hdr_byte(idx_q[1:0] + 2'd1, len_q);
                  last_d = (idx_q[1:0] == 2'd2) && (len_q == 8'd0);
               end
            end
         end
         FETCH: state_d = LOAD;
         // RAM data is valid the cycle after the strobe, i.e. in LOAD
         LOAD: begin
            byte_d  = bus.mem_data;
            vld_d   = 1'b1;
            last_d  = (idx_q == len_q - 8'd1);
            state_d = SEND;
         end
         SEND: begin
            if (accept) begin
               vld_d = 1'b0;
               if (last_q) begin
                  last_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = FETCH;
                  rd_en_d = 1'b1;
                  addr_d  = ADDR_W'(idx_q + 8'd1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         byte_q   <= '0;
         vld_q    <= 1'b0;
         last_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         wr_ack_q <= 1'b0;
         rd_ack_q <= 1'b0;
         lg_rd_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         byte_q   <= byte_d;
         vld_q    <= vld_d;
         last_q   <= last_d;
         rd_en_q  <= rd_en_d;
         addr_q   <= addr_d;
         wr_ack_q <= wr_ack_d;
         rd_ack_q <= rd_ack_d;
         lg_rd_q  <= lg_rd_d;
      end
   end

   assign wr_ack        = wr_ack_q;
   assign rd_ack        = rd_ack_q;
   assign busy          = (state_q != IDLE);
   assign bus.to_switch = byte_q;
   assign bus.tx_valid  = vld_q;
   assign bus.tx_last   = last_q;
   assign bus.mem_rd_en = rd_en_q;
   assign bus.mem_addr  = addr_q;

endmodule

// File: tb/tb_ecpri_resp_sched.sv
// Scoreboard bench: stimulus pushes expected bytes/RAM reads, a negedge monitor pops and compares.
module tb_ecpri_resp_sched;
   logic       clk = 1'b0;
   logic       reset;
   logic       send_write_resp, send_read_resp;
   logic [7:0] tx_payload_len;
   logic       wr_ack, rd_ack, busy;

   ecpri_resp_sched_if #(.ADDR_W(8)) bus ();

   ecpri_resp_sched #(.ADDR_W(8), .HDR_B0(8'h10), .HDR_B1(8'h04)) dut (
      .clk             (clk),
      .reset           (reset),
      .send_write_resp (send_write_resp),
      .send_read_resp  (send_read_resp),
      .tx_payload_len  (tx_payload_len),
      .wr_ack          (wr_ack),
      .rd_ack          (rd_ack),
      .busy            (busy),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [7:0] d; logic l; } exp_t;
   exp_t       exp_q[$];
   logic [7:0] addr_q[$];
   logic [7:0] ram [256];
   int         tests = 0, fails = 0;
   int         acc_cnt = 0, wr_cnt = 0, rd_cnt = 0;
   logic       stall_q = 1'b0;
   logic [8:0] stall_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= ram[bus.mem_addr];

   // Monitor: stream bytes, RAM read strobes and stall stability
   always @(negedge clk) begin
      if (reset) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", 32'(bus.tx_valid), 32'd1);
            check("hold_data_last", 32'({bus.to_switch, bus.tx_last}), 32'(stall_v));
         end
         if (bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_byte: got %0h expected none", bus.to_switch);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("tx_byte", 32'(bus.to_switch), 32'(e.d));
               check("tx_last", 32'(bus.tx_last), 32'(e.l));
               acc_cnt++;
            end
         end
         stall_q = bus.tx_valid && !bus.tx_ready;
         stall_v = {bus.to_switch, bus.tx_last};
         if (bus.mem_rd_en) begin
            if (addr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_rd_en: got addr %0h expected none", bus.mem_addr);
            end else begin
               check("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
            end
         end
      end
   end

   // One clock step; requests drop as soon as their ack pulse is seen
   task automatic tick();
      @(posedge clk); #1;
      if (wr_ack) begin send_write_resp = 1'b0; wr_cnt++; end
      if (rd_ack) begin send_read_resp = 1'b0; rd_cnt++; end
   endtask

   task automatic push_hdr(input logic [7:0] len);
      exp_q.push_back('{8'h10, 1'b0});
      exp_q.push_back('{8'h04, 1'b0});
      exp_q.push_back('{8'h00, 1'b0});
      exp_q.push_back('{len, len == 8'd0});
   endtask

   task automatic push_frame(input logic [7:0] len);
      push_hdr(len);
      for (int i = 0; i < int'(len); i++) begin
         exp_q.push_back('{ram[i], i == int'(len) - 1});
         addr_q.push_back(8'(i));
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy || send_write_resp || send_read_resp) && n < 3000) begin
         tick(); n++;
      end
      if (n >= 3000) begin
         tests++; fails++;
         $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
      end
      tick();
      check({name, "_busy"}, 32'(busy), 32'd0);
      check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_rd_left"}, 32'(addr_q.size()), 32'd0);
   endtask

   task automatic wait_until_acc(input int cnt);
      int n = 0;
      while (acc_cnt < cnt && n < 200) begin tick(); n++; end
      if (n >= 200) begin tests++; fails++; $display("FAIL acc_timeout: got %0d expected %0d", acc_cnt, cnt); end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.tx_valid && n < 200) begin tick(); n++; end
      if (n >= 200) begin tests++; fails++; $display("FAIL valid_timeout: got 0 expected 1"); end
   endtask

   initial begin
      ram[0] = 8'hA1; ram[1] = 8'hB2; ram[2] = 8'hC3; ram[3] = 8'hD4;
      for (int i = 4; i < 256; i++) ram[i] = 8'(i);
      reset = 1'b1; send_write_resp = 1'b0; send_read_resp = 1'b0;
      tx_payload_len = 8'd0; bus.tx_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_last", 32'(bus.tx_last), 32'd0);
      check("rst_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("rst_acks", 32'({wr_ack, rd_ack}), 32'd0);
      check("rst_byte", 32'(bus.to_switch), 32'd0);

      // 1: write response alone
      wr_cnt = 0; rd_cnt = 0;
      push_frame(8'd0); send_write_resp = 1'b1;
      wait_done("t1");
      check("t1_wr_acks", 32'(wr_cnt), 32'd1);
      check("t1_rd_acks", 32'(rd_cnt), 32'd0);

      // 2: read len 3; len input changes after grant must not matter
      wr_cnt = 0; rd_cnt = 0;
      push_frame(8'd3); tx_payload_len = 8'd3; send_read_resp = 1'b1;
      begin
         int n = 0;
         while (rd_cnt == 0 && n < 50) begin tick(); n++; end
      end
      tx_payload_len = 8'h55;
      wait_done("t2");
      check("t2_rd_acks", 32'(rd_cnt), 32'd1);

      // 3: both pending twice, last grant was read -> write wins each time
      for (int r = 0; r < 2; r++) begin
         wr_cnt = 0; rd_cnt = 0;
         push_frame(8'd0); push_frame(8'd2); tx_payload_len = 8'd2;
         send_write_resp = 1'b1; send_read_resp = 1'b1;
         wait_done("t3");
         check("t3_wr_acks", 32'(wr_cnt), 32'd1);
         check("t3_rd_acks", 32'(rd_cnt), 32'd1);
      end

      // write alone, then both -> read must win
      push_frame(8'd0); send_write_resp = 1'b1;
      wait_done("t7a");
      wr_cnt = 0; rd_cnt = 0;
      push_frame(8'd1); push_frame(8'd0); tx_payload_len = 8'd1;
      send_write_resp = 1'b1; send_read_resp = 1'b1;
      wait_done("t7b");
      check("t7_acks", 32'(wr_cnt + rd_cnt), 32'd2);

      // 4: stalls on header byte 1 and payload byte 0
      acc_cnt = 0;
      push_frame(8'd2); tx_payload_len = 8'd2; send_read_resp = 1'b1;
      wait_until_acc(1);
      bus.tx_ready = 1'b0; repeat (5) tick(); bus.tx_ready = 1'b1;
      wait_until_acc(4);
      wait_valid();
      bus.tx_ready = 1'b0; repeat (5) tick(); bus.tx_ready = 1'b1;
      wait_done("t4");

      // 5: read with zero-length payload, no RAM access
      push_frame(8'd0); tx_payload_len = 8'd0; send_read_resp = 1'b1;
      wait_done("t5");

      // 6: reset while payload byte 1 of a len-4 read is presented
      acc_cnt = 0;
      push_hdr(8'd4); exp_q.push_back('{8'hA1, 1'b0});
      addr_q.push_back(8'd0); addr_q.push_back(8'd1);
      tx_payload_len = 8'd4; send_read_resp = 1'b1;
      wait_until_acc(5);
      bus.tx_ready = 1'b0;
      wait_valid();
      check("t6_pre_byte", 32'(bus.to_switch), 32'hB2);
      reset = 1'b1; tick(); reset = 1'b0;
      check("t6_valid", 32'(bus.tx_valid), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_rd_en", 32'(bus.mem_rd_en), 32'd0);
      check("t6_last", 32'(bus.tx_last), 32'd0);
      check("t6_exp_left", 32'(exp_q.size()), 32'd0);
      check("t6_rd_left", 32'(addr_q.size()), 32'd0);
      bus.tx_ready = 1'b1;
      wr_cnt = 0;
      push_frame(8'd0); send_write_resp = 1'b1;
      wait_done("t6_after");
      check("t6_wr_acks", 32'(wr_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
